cam_capture_fmt: RTL and testbench

Parametrised OV7670 pixel-capture front end in the PCLK domain.
- Assembles two-byte camera pixels (RGB565 or YUV422) into a selectable RAM format.
- Generates row-major frame-buffer addresses with bounds checking and drives the write side of the dual-port frame RAM.
- Adds single-shot/continuous frame arming, frame-done signalling and overflow detection.

---
 rtl/cam_capture_fmt_pkg.sv | 22 ++
 rtl/cam_capture_fmt_if.sv | 27 ++
 rtl/cam_capture_fmt_px_pack.sv | 30 +++
 rtl/cam_capture_fmt.sv | 142 ++++++++++++++
 tb/tb_cam_capture_fmt.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_capture_fmt_pkg.sv
// cam_pkg: shared definitions for the OV7670 capture front end.
//   - pixel format encodings selected by the MODE parameter
//   - capture FSM state type
//   - px_width(): minimum RAM data width a format needs
package cam_pkg;

  localparam int MODE_RGB332 = 0;
  localparam int MODE_RGB444 = 1;
  localparam int MODE_Y8     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VS  = 2'd1,
    WAIT_ACT = 2'd2,
    ACTIVE   = 2'd3
  } cam_state_e;

  function automatic int px_width(input int mode);
    return (mode == MODE_RGB444) ? 12 : 8;
  endfunction

endpackage

// File: rtl/cam_capture_fmt_if.sv
// cam_capture_fmt_if: camera input bus plus frame-RAM write bus.
//   DATA/HREF/VSYNC            camera -> capture
//   DP_RAM_data_in/addr/regW   capture -> frame RAM write port
// master: camera/RAM side, slave: the capture block.
interface cam_capture_fmt_if #(
  parameter int AW = 15,
  parameter int DW = 8
) ();

  logic [7:0]    DATA;
  logic          HREF;
  logic          VSYNC;
  logic [DW-1:0] DP_RAM_data_in;
  logic [AW-1:0] DP_RAM_addr_in;
  logic          DP_RAM_regW;

  modport master (
    output DATA, HREF, VSYNC,
    input  DP_RAM_data_in, DP_RAM_addr_in, DP_RAM_regW
  );

  modport slave (
    input  DATA, HREF, VSYNC,
    output DP_RAM_data_in, DP_RAM_addr_in, DP_RAM_regW
  );

endinterface

// File: rtl/cam_capture_fmt_px_pack.sv
// cam_px_pack: combinational two-byte camera pixel -> RAM pixel converter.
//   b1  first byte of the pixel (RGB565 high byte, or Y)
//   b2  second byte of the pixel (RGB565 low byte, or U/V)
//   px  packed pixel, zero-padded in the MSBs up to DW
module cam_px_pack
  import cam_pkg::*;
#(
  parameter int MODE = MODE_RGB332,
  parameter int DW   = 8
) (
  input  logic [7:0]    b1,
  input  logic [7:0]    b2,
  output logic [DW-1:0] px
);

  // Each format keeps only the top bits of every colour channel.
  logic unused_bits;
  assign unused_bits = ^{b1, b2};

  generate
    if (MODE == MODE_RGB444) begin : g_rgb444
      assign px = DW'({b1[7:4], b1[2:0], b2[7], b2[4:1]});
    end else if (MODE == MODE_Y8) begin : g_y8
      assign px = DW'(b1);
    end else begin : g_rgb332
      assign px = DW'({b1[7:5], b1[2:0], b2[4:3]});
    end
  endgenerate

endmodule

// File: rtl/cam_capture_fmt.sv
// cam_capture_fmt: OV7670 pixel capture into a row-major frame RAM.
//   PCLK        camera pixel clock, all logic on rising edge
//   RST         asynchronous active-high reset
//   arm         request capture of the next full frame (unused when CONT=1)
//   bus         camera DATA/HREF/VSYNC in, RAM data/addr/write strobe out
//   busy        armed or capturing
//   frame_done  one-cycle pulse at end of a captured frame
//   ovf         sticky: pixels or lines beyond IMG_W/IMG_H in this frame
//   frame_cnt   captured frame count, wraps
//
// state    | meaning
// IDLE     | not armed, bytes ignored
// WAIT_VS  | armed, waiting for VSYNC high
// WAIT_ACT | inside VSYNC high, waiting for frame start
// ACTIVE   | capturing lines until VSYNC rises
module cam_capture_fmt
  import cam_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int MODE  = MODE_RGB332,
  parameter int CONT  = 0
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              arm,
  cam_capture_fmt_if.slave  bus,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf,
  output logic [7:0]        frame_cnt
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int BW = AW + 1;
  localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LIM   = RW'(IMG_H);
  localparam logic [BW-1:0] LINE_STEP = BW'(IMG_W);

  generate
    if (DW < px_width(MODE) || (2 ** AW) < IMG_W * IMG_H) begin : g_bad_param
      $error("cam_capture_fmt: DW too narrow for MODE or AW too small for frame");
    end
  endgenerate

  cam_state_e    state, state_nx;
  logic          phase;
  logic          href_q;
  logic [7:0]    b1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  // One bit wider than AW so base can reach IMG_W*IMG_H after the last line.
  logic [BW-1:0] base;
  logic [DW-1:0] px;

  logic frame_end, sample, line_end, go_active, in_bounds;

  cam_px_pack #(.MODE(MODE), .DW(DW)) u_pack (
    .b1 (b1),
    .b2 (bus.DATA),
    .px (px)
  );

  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    sample    = 1'b0;
    line_end  = 1'b0;
    go_active = 1'b0;
    in_bounds = (col < COL_LIM) && (row < ROW_LIM);
    case (state)
      IDLE:     if (arm || CONT != 0) state_nx = WAIT_VS;
      WAIT_VS:  if (bus.VSYNC) state_nx = WAIT_ACT;
      WAIT_ACT: if (!bus.VSYNC) begin
                  state_nx  = ACTIVE;
                  go_active = 1'b1;
                end
      ACTIVE:   if (bus.VSYNC) begin
                  state_nx  = IDLE;
                  frame_end = 1'b1;
                end else begin
                  sample   = bus.HREF;
                  line_end = href_q && !bus.HREF;
                end
      default:  state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      state              <= IDLE;
      phase              <= 1'b0;
      href_q             <= 1'b0;
      b1                 <= '0;
      col                <= '0;
      row                <= '0;
      base               <= '0;
      bus.DP_RAM_data_in <= '0;
      bus.DP_RAM_addr_in <= '0;
      bus.DP_RAM_regW    <= 1'b0;
      frame_done         <= 1'b0;
      ovf                <= 1'b0;
      frame_cnt          <= '0;
    end else begin
      state           <= state_nx;
      href_q          <= bus.HREF;
      bus.DP_RAM_regW <= 1'b0;
      frame_done      <= frame_end;
      phase           <= sample ? ~phase : 1'b0;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      if (go_active) ovf <= 1'b0;

      if (frame_end) begin
        col  <= '0;
        row  <= '0;
        base <= '0;
      end else if (sample) begin
        if (!phase) begin
          b1 <= bus.DATA;
        end else if (in_bounds) begin
          bus.DP_RAM_data_in <= px;
          bus.DP_RAM_addr_in <= AW'(base + BW'(col));
          bus.DP_RAM_regW    <= 1'b1;
          col                <= col + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (line_end && col != '0) begin
        // Lines that stored nothing (empty, or past IMG_H) do not advance row.
        row  <= row + 1'b1;
        base <= base + LINE_STEP;
        col  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_fmt.sv
module tb_cam_capture_fmt;
  import cam_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;

  logic       pclk = 1'b0;
  logic       rst, arm, href, vsync;
  logic [7:0] data;
  logic       busy0, busy1, busy2, fd0, fd1, fd2, ovf0, ovf1, ovf2;
  logic [7:0] fc0, fc1, fc2;

  always #5 pclk = ~pclk;

  cam_capture_fmt_if #(.AW(AW), .DW(8))  if0 ();
  cam_capture_fmt_if #(.AW(AW), .DW(12)) if1 ();
  cam_capture_fmt_if #(.AW(AW), .DW(8))  if2 ();

  assign if0.DATA = data;  assign if0.HREF = href;  assign if0.VSYNC = vsync;
  assign if1.DATA = data;  assign if1.HREF = href;  assign if1.VSYNC = vsync;
  assign if2.DATA = data;  assign if2.HREF = href;  assign if2.VSYNC = vsync;

  cam_capture_fmt #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(8), .MODE(MODE_RGB332), .CONT(0)) dut0 (
    .PCLK(pclk), .RST(rst), .arm(arm), .bus(if0),
    .busy(busy0), .frame_done(fd0), .ovf(ovf0), .frame_cnt(fc0));
  cam_capture_fmt #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(12), .MODE(MODE_RGB444), .CONT(0)) dut1 (
    .PCLK(pclk), .RST(rst), .arm(arm), .bus(if1),
    .busy(busy1), .frame_done(fd1), .ovf(ovf1), .frame_cnt(fc1));
  cam_capture_fmt #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(8), .MODE(MODE_Y8), .CONT(0)) dut2 (
    .PCLK(pclk), .RST(rst), .arm(arm), .bus(if2),
    .busy(busy2), .frame_done(fd2), .ovf(ovf2), .frame_cnt(fc2));

  typedef struct {int addr; int b1; int b2;} wr_t;
  typedef struct {int cnt; int ovf;} fd_t;
  wr_t wq0[$], wq1[$], wq2[$];
  fd_t fq0[$], fq1[$], fq2[$];

  int checks, errors;
  // frame-level reference state
  bit capturing, pending, frame_ovf;
  int row_m, cnt_m;

  // Pixel value from RGB565 channels truncated to the target channel widths.
  function automatic int ref_px(input int mode, input int b1, input int b2);
    int r, g, b;
    r = b1 >> 3;
    g = ((b1 & 7) << 3) | (b2 >> 5);
    b = b2 & 31;
    case (mode)
      0:       return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
      1:       return ((r >> 1) << 8) | ((g >> 2) << 4) | (b >> 1);
      default: return b1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic wr, input int ad, input int dv,
                     input logic fd, input int cnt, input logic ov);
    wr_t w;
    fd_t f;
    int  n;
    if (wr) begin
      n = (id == 0) ? wq0.size() : (id == 1) ? wq1.size() : wq2.size();
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL write%0d unexpected addr=%0d data=0x%0h required=no write", id, ad, dv);
      end else begin
        case (id)
          0:       w = wq0.pop_front();
          1:       w = wq1.pop_front();
          default: w = wq2.pop_front();
        endcase
        chk($sformatf("addr%0d", id), ad, w.addr);
        chk($sformatf("data%0d", id), dv, ref_px(id, w.b1, w.b2));
      end
    end
    if (fd) begin
      n = (id == 0) ? fq0.size() : (id == 1) ? fq1.size() : fq2.size();
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL frame_done%0d unexpected cnt=%0d required=no pulse", id, cnt);
      end else begin
        case (id)
          0:       f = fq0.pop_front();
          1:       f = fq1.pop_front();
          default: f = fq2.pop_front();
        endcase
        chk($sformatf("frame_cnt%0d", id), cnt, f.cnt);
        chk($sformatf("ovf%0d", id), int'(ov), f.ovf);
      end
    end
  endtask

  always @(negedge pclk) begin
    mon(0, if0.DP_RAM_regW, int'(if0.DP_RAM_addr_in), int'(if0.DP_RAM_data_in), fd0, int'(fc0), ovf0);
    mon(1, if1.DP_RAM_regW, int'(if1.DP_RAM_addr_in), int'(if1.DP_RAM_data_in), fd1, int'(fc1), ovf1);
    mon(2, if2.DP_RAM_regW, int'(if2.DP_RAM_addr_in), int'(if2.DP_RAM_data_in), fd2, int'(fc2), ovf2);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push_wr(input int a, input int b1, input int b2);
    wr_t w;
    w.addr = a; w.b1 = b1; w.b2 = b2;
    wq0.push_back(w); wq1.push_back(w); wq2.push_back(w);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    if (!capturing) pending = 1'b1;
    chk("busy_after_arm", {busy0, busy1, busy2}, (capturing || pending) ? 7 : 0);
  endtask

  // Ends the current frame (VSYNC high period) and starts the next one.
  task automatic vs_pulse();
    fd_t f;
    if (capturing) begin
      cnt_m = (cnt_m + 1) % 256;
      f.cnt = cnt_m; f.ovf = frame_ovf;
      fq0.push_back(f); fq1.push_back(f); fq2.push_back(f);
    end
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    capturing = pending;
    pending   = 1'b0;
    frame_ovf = 1'b0;
    row_m     = 0;
    tick(2);
  endtask

  // A line of nb bytes; pat=0 random bytes, otherwise repeating {pat[15:8], pat[7:0]}.
  task automatic drive_line(input int nb, input int pat);
    int b1v, col;
    b1v = 0;
    col = 0;
    if (nb == 0) return;
    href = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (pat == 0) data = 8'($urandom);
      else          data = (i % 2 == 0) ? pat[15:8] : pat[7:0];
      if (i % 2 == 0) b1v = int'(data);
      else if (capturing) begin
        if (row_m < H && col < W) begin
          push_wr(row_m * W + col, b1v, int'(data));
          col++;
        end else begin
          frame_ovf = 1'b1;
        end
      end
      tick(1);
    end
    href = 1'b0;
    if (capturing && col > 0) row_m++;
    tick(2);
  endtask

  task automatic frame(input int arm_at, input int nlines, input int pat);
    for (int l = 0; l < nlines; l++) begin
      if ((arm_at == 1 && l == 0) || (arm_at == 2 && l == nlines / 2)) do_arm();
      drive_line((pat != 0) ? 2 * W : int'($urandom_range(0, 11)), pat);
    end
    if (arm_at == 3) do_arm();
    vs_pulse();
  endtask

  // Three full pixels and the first byte of the fourth, then reset.
  task automatic line_rst();
    int b1v;
    b1v = 0;
    href = 1'b1;
    for (int i = 0; i < 7; i++) begin
      data = 8'($urandom);
      if (i % 2 == 0) b1v = int'(data);
      else push_wr(row_m * W + i / 2, b1v, int'(data));
      tick(1);
    end
    rst  = 1'b1;
    href = 1'b0;
    #2;
    chk("rst_regw", {if0.DP_RAM_regW, if1.DP_RAM_regW, if2.DP_RAM_regW}, 0);
    chk("rst_addr", {if0.DP_RAM_addr_in, if1.DP_RAM_addr_in, if2.DP_RAM_addr_in}, 0);
    chk("rst_data", {if0.DP_RAM_data_in, if1.DP_RAM_data_in, if2.DP_RAM_data_in}, 0);
    chk("rst_flags", {busy0, busy1, busy2, ovf0, ovf1, ovf2, fd0, fd1, fd2}, 0);
    chk("rst_cnt", {fc0, fc1, fc2}, 0);
    capturing = 1'b0;
    pending   = 1'b0;
    cnt_m     = 0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    checks = 0; errors = 0;
    capturing = 1'b0; pending = 1'b0; frame_ovf = 1'b0;
    row_m = 0; cnt_m = 0;
    rst = 1'b1; arm = 1'b0; href = 1'b0; vsync = 1'b0; data = 8'h00;
    tick(3);
    chk("reset_flags", {if0.DP_RAM_regW, if1.DP_RAM_regW, if2.DP_RAM_regW,
                        busy0, busy1, busy2, ovf0, ovf1, ovf2, fd0, fd1, fd2}, 0);
    chk("reset_cnt", {fc0, fc1, fc2}, 0);
    chk("reset_addr", {if0.DP_RAM_addr_in, if1.DP_RAM_addr_in, if2.DP_RAM_addr_in}, 0);
    chk("reset_data", {if0.DP_RAM_data_in, if1.DP_RAM_data_in, if2.DP_RAM_data_in}, 0);
    rst = 1'b0;
    tick(2);

    // no arm: full frame must not be captured
    vs_pulse();
    frame(0, 3, 0);
    chk("noarm_busy", {busy0, busy1, busy2}, 0);
    chk("noarm_cnt", {fc0, fc1, fc2}, 0);

    // fixed-pattern frames
    do_arm(); vs_pulse(); frame(0, 2, 16'hF81F);
    do_arm(); vs_pulse(); frame(0, 1, 16'hA53C);

    // long line overflow, next line continues at row 1; ovf clears next frame
    do_arm(); vs_pulse();
    drive_line(12, 0);
    drive_line(8, 0);
    vs_pulse();
    do_arm(); vs_pulse();
    drive_line(4, 0);
    vs_pulse();

    // arm mid-frame, then an odd 7-byte line
    frame(2, 3, 0);
    drive_line(7, 0);
    drive_line(6, 0);
    vs_pulse();

    // randomized frames, including too many lines and arm while capturing
    for (int f = 0; f < 14; f++)
      frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0);

    // reset in the middle of a pixel
    if (!capturing) begin do_arm(); vs_pulse(); end
    drive_line(4, 0);
    line_rst();
    drive_line(6, 0);
    vs_pulse();
    frame(0, 2, 0);
    do_arm(); vs_pulse();
    drive_line(6, 0);
    vs_pulse();

    tick(5);
    chk("writes_left", wq0.size() + wq1.size() + wq2.size(), 0);
    chk("frames_left", fq0.size() + fq1.size() + fq2.size(), 0);
    chk("final_cnt0", int'(fc0), cnt_m);
    chk("final_cnt1", int'(fc1), cnt_m);
    chk("final_cnt2", int'(fc2), cnt_m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
